// File: rtl/seq_multiplier_if.sv
// Start/done handshake and result bus shared by the ALU and its iterative multiplier.
interface seq_multiplier_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] hi;
  logic [N-1:0] lo;
  logic [3:0]   flags;

  modport master (
    output start, a, b,
    input  busy, done, hi, lo, flags
  );

  modport slave (
    input  start, a, b,
    output busy, done, hi, lo, flags
  );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative unsigned shift-and-add multiplier: one multiplier bit per cycle, fixed N-cycle run,
// 2N-bit product {hi,lo} plus ALU-format flags {N,Z,C,V}.
module seq_multiplier #(
  parameter int N = 8
) (
  input logic              clk,
  input logic              rst_n,
  seq_multiplier_if.slave  mul_if
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q;
  logic [N-1:0]   mcand_q;
  logic [2*N-1:0] acc_q;
  logic [CW-1:0]  count_q;
  logic           busy_q;
  logic           done_q;
  logic [N-1:0]   hi_q;
  logic [N-1:0]   lo_q;
  logic [3:0]     flags_q;

  logic [N:0]     sum_d;
  logic [2*N-1:0] acc_d;
  logic [3:0]     flags_d;

  // The adder is N+1 bits wide so its carry lands in the accumulator MSB after the shift.
  always_comb begin
    sum_d   = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, mcand_q} : {(N+1){1'b0}});
    acc_d   = {sum_d, acc_q[N-1:1]};
    flags_d = {acc_d[N-1], (acc_d == '0), (acc_d[2*N-1:N] != '0), 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      flags_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (mul_if.start) begin
            mcand_q <= mul_if.a;
            acc_q   <= {{N{1'b0}}, mul_if.b};
            count_q <= CW'(N);
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          acc_q   <= acc_d;
          count_q <= count_q - CW'(1);
          // Results are published only on the final step and then held until the next completion.
          if (count_q == CW'(1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            hi_q    <= acc_d[2*N-1:N];
            lo_q    <= acc_d[N-1:0];
            flags_q <= flags_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mul_if.busy  = busy_q;
  assign mul_if.done  = done_q;
  assign mul_if.hi    = hi_q;
  assign mul_if.lo    = lo_q;
  assign mul_if.flags = flags_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and randomized checks of seq_multiplier (N=8) against a plain a*b reference model.
module tb_seq_multiplier;

  localparam int N = 8;

  logic clk;
  logic rst_n;
  int   totalCount;
  int   badCount;
  int   lat;
  bit   sawDone;

  seq_multiplier_if #(.N(N)) mif ();

  seq_multiplier #(.N(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .mul_if (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCount++;
    assert (obs === exp)
    else begin
      badCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: the product is just a*b; flags follow from the product's value.
  task automatic checkOutput(input string tag, input int av, input int bv);
    int       p;
    logic [3:0] f;
    p = av * bv;
    f = {((p >> 7) & 1) == 1, p == 0, p > 255, 1'b0};
    checkValue({tag, ".hi"},    32'(mif.hi),    32'((p >> 8) & 255));
    checkValue({tag, ".lo"},    32'(mif.lo),    32'(p & 255));
    checkValue({tag, ".flags"}, 32'(mif.flags), 32'(f));
  endtask

  // Called at a negedge; the request is taken at the following posedge.
  task automatic applyStimulus(input logic [N-1:0] av, input logic [N-1:0] bv);
    mif.start = 1'b1;
    mif.a     = av;
    mif.b     = bv;
  endtask

  // Counts negedges until done; operands are scrambled after accept to prove they were latched.
  task automatic waitDone(input string tag, output int cycles);
    bit overlap;
    cycles  = 0;
    overlap = 1'b0;
    do begin
      @(negedge clk);
      cycles++;
      mif.start = 1'b0;
      mif.a     = N'($urandom);
      mif.b     = N'($urandom);
      if (mif.busy && mif.done) overlap = 1'b1;
    end while (!mif.done && cycles < 40);
    checkValue({tag, ".doneSeen"}, 32'(mif.done), 32'd1);
    checkValue({tag, ".busyDoneOverlap"}, 32'(overlap), 32'd0);
  endtask

  task automatic runOp(input string tag, input int av, input int bv);
    int c;
    applyStimulus(N'(av), N'(bv));
    waitDone(tag, c);
    checkValue({tag, ".latency"}, 32'(c), 32'(N + 1));
    checkOutput(tag, av, bv);
  endtask

  initial begin
    totalCount = 0;
    badCount   = 0;
    rst_n      = 1'b0;
    mif.start  = 1'b0;
    mif.a      = '0;
    mif.b      = '0;

    repeat (2) @(negedge clk);
    checkValue("reset.busy",  32'(mif.busy),  32'd0);
    checkValue("reset.done",  32'(mif.done),  32'd0);
    checkValue("reset.hi",    32'(mif.hi),    32'd0);
    checkValue("reset.lo",    32'(mif.lo),    32'd0);
    checkValue("reset.flags", 32'(mif.flags), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    runOp("mul13x11", 13, 11);
    @(negedge clk);
    checkValue("mul13x11.donePulse", 32'(mif.done), 32'd0);
    checkValue("mul13x11.idleBusy",  32'(mif.busy), 32'd0);
    checkOutput("mul13x11.held", 13, 11);

    runOp("mul255x255", 255, 255);
    @(negedge clk);
    runOp("mul0xA5", 0, 'hA5);
    @(negedge clk);
    runOp("mulA5x0", 'hA5, 0);
    @(negedge clk);

    // A start pulse mid-run with different operands must be ignored.
    applyStimulus(8'd7, 8'd6);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      mif.start = 1'b0;
      if (lat == 3) applyStimulus(8'd2, 8'd2);
    end while (!mif.done && lat < 40);
    checkValue("midStart.doneSeen", 32'(mif.done), 32'd1);
    checkValue("midStart.latency",  32'(lat),      32'(N + 1));
    checkOutput("midStart", 7, 6);
    @(negedge clk);

    // Reset in the middle of a run aborts it and clears the outputs.
    applyStimulus(8'd200, 8'd3);
    repeat (4) begin
      @(negedge clk);
      mif.start = 1'b0;
    end
    checkValue("abort.busyBefore", 32'(mif.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkValue("abort.busy",  32'(mif.busy),  32'd0);
    checkValue("abort.done",  32'(mif.done),  32'd0);
    checkValue("abort.hi",    32'(mif.hi),    32'd0);
    checkValue("abort.lo",    32'(mif.lo),    32'd0);
    checkValue("abort.flags", 32'(mif.flags), 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    sawDone = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (mif.done || mif.busy) sawDone = 1'b1;
    end
    checkValue("abort.noActivity", 32'(sawDone), 32'd0);
    runOp("mul200x3", 200, 3);

    // Back-to-back: the next request is issued during the DONE cycle.
    @(negedge clk);
    runOp("mul16x16", 16, 16);
    applyStimulus(8'd3, 8'd5);
    waitDone("mul3x5", lat);
    checkValue("mul3x5.latency", 32'(lat), 32'(N + 1));
    checkOutput("mul3x5", 3, 5);
    @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      int ra;
      int rb;
      ra = int'($urandom_range(255, 0));
      rb = int'($urandom_range(255, 0));
      runOp($sformatf("rand%0d_%0dx%0d", i, ra, rb), ra, rb);
      if (($urandom & 1) == 1) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
